// File: rtl/apb_slave_regfile.sv
// APB completer with a bank of 8-bit registers, fixed wait states and pslverr reporting.
// Optional macro APB_SLV_STABLE_CHECK_EN flags transfers whose paddr/pwrite/pwdata move during wait states.
module apb_slave_regfile #(
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [15:0] RO_MASK     = 16'h0000
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [3:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);
    localparam logic [2:0] CNT_INIT   = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    state_t     state;
    state_t     state_next;
    logic [2:0] cnt;
    logic [3:0] cap_addr;
    logic       cap_write;
    logic [7:0] cap_wdata;
    logic [7:0] regs [16];

    logic       start;
    logic [3:0] eff_addr;
    logic       eff_write;
    logic [7:0] eff_wdata;
    logic       unstable;
    logic       enter_resp;
    logic       err;
    logic       commit;

    assign start = (state == ST_IDLE) && psel && penable;

    always_comb begin
        // NOTE: default assignment first keeps this block purely combinational (no latch).
        state_next = state;
        case (state)
            ST_IDLE: if (psel && penable) state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: begin
                if (!psel)          state_next = ST_IDLE;
                else if (cnt == '0) state_next = ST_RESP;
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        // NOTE: sequential state uses <= so every process sees pre-edge values.
        if (!presetn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cap_addr  <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                cap_addr  <= paddr;
                cap_write <= pwrite;
                cap_wdata <= pwdata;
                cnt       <= CNT_INIT;
            end else if (state == ST_WAIT && cnt != '0) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    // With zero wait states RESP is entered straight from IDLE, before the capture lands.
    assign eff_addr  = (state == ST_IDLE) ? paddr  : cap_addr;
    assign eff_write = (state == ST_IDLE) ? pwrite : cap_write;
    assign eff_wdata = (state == ST_IDLE) ? pwdata : cap_wdata;

`ifdef APB_SLV_STABLE_CHECK_EN
    logic unstable_flag;
    logic mismatch;

    assign mismatch = (state == ST_WAIT) &&
                      ((paddr != cap_addr) || (pwrite != cap_write) ||
                       (cap_write && (pwdata != cap_wdata)));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)                   unstable_flag <= 1'b0;
        else if (state_next == ST_WAIT) unstable_flag <= unstable_flag | mismatch;
        else                            unstable_flag <= 1'b0;
    end

    assign unstable = unstable_flag | mismatch;
`else
    assign unstable = 1'b0;
`endif

    assign enter_resp = (state_next == ST_RESP);
    assign err        = ({1'b0, eff_addr} >= NUM_REGS_W) ||
                        (eff_write && RO_MASK[eff_addr]) || unstable;
    assign commit     = enter_resp && eff_write && !err;

    always_ff @(posedge pclk or negedge presetn) begin
        // NOTE: this bank is flops rather than a RAM macro, so clearing every entry on reset is legal.
        if (!presetn) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (commit) begin
            regs[eff_addr] <= eff_wdata;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            pready  <= enter_resp;
            pslverr <= enter_resp && err;
            prdata  <= (enter_resp && !eff_write && !err) ? regs[eff_addr] : 8'h00;
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile: three instances (default, 8 regs/RO reg 0/no wait, 3 wait states).
module tb_apb_slave_regfile;

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       psel_v [3];
    logic       penable;
    logic       pwrite;
    logic [3:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata_v [3];
    logic       pready_v [3];
    logic       pslverr_v [3];

    always #5 pclk = ~pclk;

    apb_slave_regfile #(.NUM_REGS(16), .WAIT_CYCLES(1), .RO_MASK(16'h0000)) dut0 (
        .pclk(pclk), .presetn(presetn), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]), .pready(pready_v[0]), .pslverr(pslverr_v[0]));

    apb_slave_regfile #(.NUM_REGS(8), .WAIT_CYCLES(0), .RO_MASK(16'h0001)) dut1 (
        .pclk(pclk), .presetn(presetn), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]), .pready(pready_v[1]), .pslverr(pslverr_v[1]));

    apb_slave_regfile #(.NUM_REGS(16), .WAIT_CYCLES(3), .RO_MASK(16'h0000)) dut2 (
        .pclk(pclk), .presetn(presetn), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[2]), .pready(pready_v[2]), .pslverr(pslverr_v[2]));

    typedef struct {
        int         inst;
        logic       write;
        logic [3:0] addr;
        logic       err;
        logic [7:0] rdata;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   lat_tab [3] = '{3, 2, 5};

    task automatic bus_idle();
        @(posedge pclk); #1;
        for (int i = 0; i < 3; i++) psel_v[i] = 1'b0;
        penable = 1'b0;
    endtask

    // Drives one transfer, pushes its expectation, pops and compares when pready arrives.
    task automatic xfer(input int inst, input logic wr, input logic [3:0] addr, input logic [7:0] wdata,
                        input logic exp_err, input logic [7:0] exp_rdata,
                        input int mut_cyc = 0, input logic [7:0] mut_data = 8'h00);
        exp_t e;
        int   cyc;
        bit   done;
        e.inst = inst; e.write = wr; e.addr = addr; e.err = exp_err; e.rdata = exp_rdata; e.lat = lat_tab[inst];
        sb.push_back(e);
        @(posedge pclk); #1;
        for (int i = 0; i < 3; i++) psel_v[i] = (i == inst);
        penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge pclk); #1;
        penable = 1'b1;
        cyc = 1;
        done = 1'b0;
        while (!done && cyc <= 20) begin
            @(negedge pclk);
            if (pready_v[inst] === 1'b1) done = 1'b1;
            else begin
                @(posedge pclk); #1;
                cyc++;
                if (cyc == mut_cyc) pwdata = mut_data;
            end
        end
        e = sb.pop_front();
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL timeout i%0d a%h: no pready after %0d access cycles", e.inst, e.addr, cyc - 1);
        end else begin
            if (cyc !== e.lat) begin
                n_fail++;
                $display("FAIL latency i%0d a%h: got cycle %0d want %0d", e.inst, e.addr, cyc, e.lat);
            end
            n_tests++;
            if (pslverr_v[e.inst] !== e.err) begin
                n_fail++;
                $display("FAIL pslverr i%0d a%h: got %b want %b", e.inst, e.addr, pslverr_v[e.inst], e.err);
            end
            if (!e.write) begin
                n_tests++;
                if (prdata_v[e.inst] !== e.rdata) begin
                    n_fail++;
                    $display("FAIL prdata i%0d a%h: got %h want %h", e.inst, e.addr, prdata_v[e.inst], e.rdata);
                end
            end
        end
    endtask

    task automatic test_reset();
        #3;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (pready_v[i] !== 1'b0 || pslverr_v[i] !== 1'b0 || prdata_v[i] !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_outputs i%0d: got %b/%b/%h want 0/0/00", i, pready_v[i], pslverr_v[i], prdata_v[i]);
            end
        end
        @(negedge pclk); presetn = 1'b1;

        xfer(0, 1'b1, 4'h3, 8'h77, 1'b0, 8'h00);
        xfer(0, 1'b0, 4'h3, 8'h00, 1'b0, 8'h77);
        presetn = 1'b0;
        #1;
        n_tests++;
        if (pready_v[0] !== 1'b0 || prdata_v[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset_resp: got pready %b prdata %h want 0/00", pready_v[0], prdata_v[0]);
        end
        psel_v[0] = 1'b0; penable = 1'b0;
        @(negedge pclk); presetn = 1'b1;

        @(posedge pclk); #1;
        psel_v[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h3; pwdata = 8'h99;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        presetn = 1'b0;
        #1;
        n_tests++;
        if (pready_v[0] !== 1'b0 || pslverr_v[0] !== 1'b0 || prdata_v[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got %b/%b/%h want 0/0/00", pready_v[0], pslverr_v[0], prdata_v[0]);
        end
        psel_v[0] = 1'b0; penable = 1'b0;
        @(negedge pclk); presetn = 1'b1;
        xfer(0, 1'b0, 4'h3, 8'h00, 1'b0, 8'h00);
        bus_idle();
    endtask

    task automatic test_write_read();
        xfer(0, 1'b1, 4'h2, 8'hA5, 1'b0, 8'h00);
        xfer(0, 1'b0, 4'h2, 8'h00, 1'b0, 8'hA5);
        bus_idle();
        @(negedge pclk);
        n_tests++;
        if (pready_v[0] !== 1'b0 || prdata_v[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL resp_one_cycle: got pready %b prdata %h want 0/00", pready_v[0], prdata_v[0]);
        end
    endtask

    task automatic test_read_only();
        xfer(1, 1'b1, 4'h0, 8'h5A, 1'b1, 8'h00);
        xfer(1, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00);
        xfer(1, 1'b1, 4'h1, 8'hC3, 1'b0, 8'h00);
        xfer(1, 1'b0, 4'h1, 8'h00, 1'b0, 8'hC3);
        bus_idle();
    endtask

    task automatic test_out_of_range();
        xfer(1, 1'b0, 4'hC, 8'h00, 1'b1, 8'h00);
        for (int i = 1; i < 8; i++) xfer(1, 1'b1, 4'(i), 8'(8'h10 + i), 1'b0, 8'h00);
        xfer(1, 1'b1, 4'h9, 8'hFF, 1'b1, 8'h00);
        xfer(1, 1'b1, 4'h8, 8'hEE, 1'b1, 8'h00);
        xfer(1, 1'b0, 4'h8, 8'h00, 1'b1, 8'h00);
        for (int i = 0; i < 8; i++) xfer(1, 1'b0, 4'(i), 8'h00, 1'b0, (i == 0) ? 8'h00 : 8'(8'h10 + i));
        bus_idle();
    endtask

    task automatic test_back_to_back();
        xfer(0, 1'b1, 4'h1, 8'h11, 1'b0, 8'h00);
        xfer(0, 1'b1, 4'h2, 8'h22, 1'b0, 8'h00);
        xfer(0, 1'b1, 4'h3, 8'h33, 1'b0, 8'h00);
        xfer(0, 1'b0, 4'h1, 8'h00, 1'b0, 8'h11);
        xfer(0, 1'b0, 4'h2, 8'h00, 1'b0, 8'h22);
        xfer(0, 1'b0, 4'h3, 8'h00, 1'b0, 8'h33);
        bus_idle();
    endtask

    task automatic test_abort();
        int seen;
        xfer(0, 1'b1, 4'h5, 8'h55, 1'b0, 8'h00);
        bus_idle();
        seen = 0;
        @(posedge pclk); #1;
        psel_v[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h5; pwdata = 8'h66;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        if (pready_v[0] === 1'b1) seen++;
        @(posedge pclk); #1;
        psel_v[0] = 1'b0; penable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            if (pready_v[0] === 1'b1) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL abort_no_pready: got %0d pready cycles want 0", seen);
        end
        xfer(0, 1'b0, 4'h5, 8'h00, 1'b0, 8'h55);
        bus_idle();
    endtask

    task automatic test_stable_check();
        xfer(2, 1'b1, 4'h4, 8'h44, 1'b0, 8'h00);
        xfer(2, 1'b0, 4'h4, 8'h00, 1'b0, 8'h44);
`ifdef APB_SLV_STABLE_CHECK_EN
        xfer(2, 1'b1, 4'h4, 8'h10, 1'b1, 8'h00, 3, 8'h20);
        xfer(2, 1'b0, 4'h4, 8'h00, 1'b0, 8'h44);
`else
        xfer(2, 1'b1, 4'h4, 8'h10, 1'b0, 8'h00, 3, 8'h20);
        xfer(2, 1'b0, 4'h4, 8'h00, 1'b0, 8'h10);
`endif
        xfer(2, 1'b1, 4'h4, 8'h66, 1'b0, 8'h00);
        xfer(2, 1'b0, 4'h4, 8'h00, 1'b0, 8'h66);
        bus_idle();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) psel_v[i] = 1'b0;
        penable = 1'b0; pwrite = 1'b0; paddr = 4'h0; pwdata = 8'h00;
        test_reset();
        test_write_read();
        test_read_only();
        test_out_of_range();
        test_back_to_back();
        test_abort();
        test_stable_check();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
